// File: rtl/ex_mem_pkg.sv
// Shared types and widths for the EX/MEM pipeline register and its skid buffer.
package ex_mem_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 6;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       store_data;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
  } ex_mem_payload_t;

  localparam int unsigned PAYLOAD_W = $bits(ex_mem_payload_t);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush; ready_o and valid_o are
// registered so no combinational ready_i->ready_o path exists.
module pipe_skid_buf
  import ex_mem_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  occ_state_t   r_state;
  occ_state_t   w_state_nxt;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         r_valid;
  logic         r_ready;
  logic         w_in;
  logic         w_out;
  logic         w_load_main;
  logic         w_load_skid;
  logic         w_skid_to_main;

  assign w_in  = valid_i & r_ready;
  assign w_out = r_valid & ready_i;

  // Next occupancy and which register captures what this cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_in) begin
          w_state_nxt = ONE;
          w_load_main = 1'b1;
        end
      end
      ONE: begin
        if (w_in && w_out) begin
          w_load_main = 1'b1;
        end else if (w_in) begin
          w_state_nxt = FULL;
          w_load_skid = 1'b1;
        end else if (w_out) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_out) begin
          w_state_nxt    = ONE;
          w_skid_to_main = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    if (flush_i) begin
      w_state_nxt    = EMPTY;
      w_load_main    = 1'b0;
      w_load_skid    = 1'b0;
      w_skid_to_main = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt != EMPTY);
      r_ready <= (w_state_nxt != FULL);
      if (w_load_main) begin
        r_main <= data_i;
      end else if (w_skid_to_main) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= data_i;
      end
    end
  end

  assign ready_o = r_ready;
  assign valid_o = r_valid;
  assign data_o  = r_main;

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register: packs the EX bundle, kills writes to register 0,
// drives the forwarding tap. Define EX_MEM_PERF_EN to add stall_cnt_o.
module ex_mem_skid_reg
  import ex_mem_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [XLEN-1:0]       alu_result_i,
  input  logic [XLEN-1:0]       store_data_i,
  input  logic                  reg_write_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic                  mem_to_reg_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [XLEN-1:0]       alu_result_o,
  output logic [XLEN-1:0]       store_data_o,
  output logic                  reg_write_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic                  mem_to_reg_o,
  output logic                  fwd_valid_o,
  output logic [REG_ADDR_W-1:0] fwd_addr_o,
  output logic [XLEN-1:0]       fwd_data_o
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  ex_mem_payload_t w_in_pl;
  ex_mem_payload_t w_out_pl;
  logic [PAYLOAD_W-1:0] w_out_bits;

  // Register 0 is hardwired; never let a write to it reach forwarding or WB.
  always_comb begin
    w_in_pl            = '0;
    w_in_pl.rd_addr    = rd_addr_i;
    w_in_pl.alu_result = alu_result_i;
    w_in_pl.store_data = store_data_i;
    w_in_pl.reg_write  = reg_write_i & (rd_addr_i != '0);
    w_in_pl.mem_read   = mem_read_i;
    w_in_pl.mem_write  = mem_write_i;
    w_in_pl.mem_to_reg = mem_to_reg_i;
  end

  pipe_skid_buf #(
    .W (PAYLOAD_W)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (w_in_pl),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (w_out_bits)
  );

  assign w_out_pl     = ex_mem_payload_t'(w_out_bits);
  assign rd_addr_o    = w_out_pl.rd_addr;
  assign alu_result_o = w_out_pl.alu_result;
  assign store_data_o = w_out_pl.store_data;
  assign reg_write_o  = w_out_pl.reg_write;
  assign mem_read_o   = w_out_pl.mem_read;
  assign mem_write_o  = w_out_pl.mem_write;
  assign mem_to_reg_o = w_out_pl.mem_to_reg;

  assign fwd_valid_o  = valid_o & w_out_pl.reg_write;
  assign fwd_addr_o   = w_out_pl.rd_addr;
  assign fwd_data_o   = w_out_pl.alu_result;

`ifdef EX_MEM_PERF_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles MEM holds off a valid head entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (valid_o && !ready_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed self-checking bench for ex_mem_skid_reg (EX_MEM_PERF_EN optional).
module tb_ex_mem_skid_reg;
  import ex_mem_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  flush_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [REG_ADDR_W-1:0] rd_addr_i;
  logic [XLEN-1:0]       alu_result_i;
  logic [XLEN-1:0]       store_data_i;
  logic                  reg_write_i;
  logic                  mem_read_i;
  logic                  mem_write_i;
  logic                  mem_to_reg_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [REG_ADDR_W-1:0] rd_addr_o;
  logic [XLEN-1:0]       alu_result_o;
  logic [XLEN-1:0]       store_data_o;
  logic                  reg_write_o;
  logic                  mem_read_o;
  logic                  mem_write_o;
  logic                  mem_to_reg_o;
  logic                  fwd_valid_o;
  logic [REG_ADDR_W-1:0] fwd_addr_o;
  logic [XLEN-1:0]       fwd_data_o;
`ifdef EX_MEM_PERF_EN
  logic [31:0]           stall_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  ex_mem_skid_reg dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .rd_addr_i    (rd_addr_i),
    .alu_result_i (alu_result_i),
    .store_data_i (store_data_i),
    .reg_write_i  (reg_write_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .mem_to_reg_i (mem_to_reg_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .rd_addr_o    (rd_addr_o),
    .alu_result_o (alu_result_o),
    .store_data_o (store_data_o),
    .reg_write_o  (reg_write_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_to_reg_o (mem_to_reg_o),
    .fwd_valid_o  (fwd_valid_o),
    .fwd_addr_o   (fwd_addr_o),
    .fwd_data_o   (fwd_data_o)
`ifdef EX_MEM_PERF_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [REG_ADDR_W-1:0] rd, input logic [XLEN-1:0] alu,
                      input logic rw);
    valid_i      = 1'b1;
    rd_addr_i    = rd;
    alu_result_i = alu;
    store_data_i = alu + 32'h1000;
    reg_write_i  = rw;
  endtask

  task automatic idle_in();
    valid_i      = 1'b0;
    rd_addr_i    = '0;
    alu_result_i = '0;
    store_data_i = '0;
    reg_write_i  = 1'b0;
    mem_read_i   = 1'b0;
    mem_write_i  = 1'b0;
    mem_to_reg_i = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [REG_ADDR_W-1:0] rd,
                            input logic [XLEN-1:0] alu);
    check({tag, "_valid"}, 64'(valid_o), 64'd1);
    check({tag, "_rd"},    64'(rd_addr_o), 64'(rd));
    check({tag, "_alu"},   64'(alu_result_o), 64'(alu));
    check({tag, "_st"},    64'(store_data_o), 64'(alu + 32'h1000));
  endtask

  initial begin
    rst_i   = 1'b1;
    flush_i = 1'b0;
    ready_i = 1'b0;
    idle_in();

    // Reset then idle
    tick();
    tick();
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_fwd_valid", 64'(fwd_valid_o), 64'd0);
    check("rst_rd", 64'(rd_addr_o), 64'd0);
    check("rst_alu", 64'(alu_result_o), 64'd0);
    check("rst_st", 64'(store_data_o), 64'd0);
    check("rst_ctrl", 64'({reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o}), 64'd0);
`ifdef EX_MEM_PERF_EN
    check("rst_stall_cnt", 64'(stall_cnt_o), 64'd0);
`endif
    rst_i = 1'b0;
    tick();
    check("idle_valid", 64'(valid_o), 64'd0);

    // Streaming with MEM always ready
    ready_i = 1'b1;
    send(6'd5, 32'h10, 1'b1);
    tick();
    check_head("s5", 6'd5, 32'h10);
    check("s5_ready", 64'(ready_o), 64'd1);
    check("s5_fwd", 64'({fwd_valid_o, fwd_addr_o, fwd_data_o}), 64'({1'b1, 6'd5, 32'h10}));
    send(6'd6, 32'h20, 1'b1);
    tick();
    check_head("s6", 6'd6, 32'h20);
    check("s6_ready", 64'(ready_o), 64'd1);
    send(6'd7, 32'h30, 1'b1);
    tick();
    check_head("s7", 6'd7, 32'h30);
    check("s7_ready", 64'(ready_o), 64'd1);
    idle_in();
    tick();
    check("drain_valid", 64'(valid_o), 64'd0);
    check("drain_fwd_valid", 64'(fwd_valid_o), 64'd0);

    // Backpressure: fill main then skid, third bundle held off
    ready_i = 1'b0;
    send(6'd8, 32'h80, 1'b1);
    tick();
    check_head("bp8", 6'd8, 32'h80);
    check("bp8_ready", 64'(ready_o), 64'd1);
    send(6'd9, 32'h90, 1'b1);
    tick();
    check_head("bp_full", 6'd8, 32'h80);
    check("bp_full_ready", 64'(ready_o), 64'd0);
    send(6'd11, 32'hB0, 1'b1);
    tick();
    check_head("bp_hold", 6'd8, 32'h80);
    check("bp_hold_ready", 64'(ready_o), 64'd0);
    idle_in();
    ready_i = 1'b1;
    tick();
    check_head("bp9", 6'd9, 32'h90);
    check("bp9_ready", 64'(ready_o), 64'd1);
    tick();
    check("bp_empty", 64'(valid_o), 64'd0);

    // Flush collides with an in-transfer while in ONE
    ready_i = 1'b0;
    send(6'd12, 32'hC0, 1'b1);
    tick();
    check_head("fl12", 6'd12, 32'hC0);
    send(6'd10, 32'hA0, 1'b1);
    flush_i = 1'b1;
    tick();
    check("fl_valid", 64'(valid_o), 64'd0);
    check("fl_ready", 64'(ready_o), 64'd1);
    check("fl_fwd_valid", 64'(fwd_valid_o), 64'd0);
    flush_i = 1'b0;
    idle_in();
    ready_i = 1'b1;
    tick();
    tick();
    check("fl_no_rd10", 64'(valid_o), 64'd0);

    // Register 0 write kill, other controls pass through
    send(6'd0, 32'hDEAD, 1'b1);
    mem_read_i   = 1'b1;
    mem_to_reg_i = 1'b1;
    tick();
    check("z_valid", 64'(valid_o), 64'd1);
    check("z_reg_write", 64'(reg_write_o), 64'd0);
    check("z_fwd_valid", 64'(fwd_valid_o), 64'd0);
    check("z_alu", 64'(alu_result_o), 64'hDEAD);
    check("z_ctrl", 64'({mem_read_o, mem_write_o, mem_to_reg_o}), 64'b101);
    send(6'd3, 32'h33, 1'b0);
    mem_write_i = 1'b1;
    tick();
    check("nw_ctrl", 64'({reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o}), 64'b0111);
    check("nw_fwd_valid", 64'(fwd_valid_o), 64'd0);
    idle_in();
    tick();

`ifdef EX_MEM_PERF_EN
    // Stall counter: clean start, 7 stalled cycles, flush keeps it, reset clears it
    rst_i = 1'b1;
    tick();
    rst_i   = 1'b0;
    ready_i = 1'b0;
    send(6'd4, 32'h40, 1'b1);
    tick();
    idle_in();
    for (int i = 0; i < 7; i++) tick();
    check("perf_7", 64'(stall_cnt_o), 64'd7);
    ready_i = 1'b1;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick();
    check("perf_flush", 64'(stall_cnt_o), 64'd7);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("perf_rst", 64'(stall_cnt_o), 64'd0);
`endif

    // Reset mid-operation overrides flush and valid_i
    ready_i = 1'b0;
    send(6'd20, 32'h200, 1'b1);
    tick();
    send(6'd21, 32'h210, 1'b1);
    tick();
    check("mr_full_ready", 64'(ready_o), 64'd0);
    rst_i   = 1'b1;
    flush_i = 1'b1;
    tick();
    check("mr_valid", 64'(valid_o), 64'd0);
    check("mr_ready", 64'(ready_o), 64'd1);
    check("mr_payload", 64'({rd_addr_o, alu_result_o}), 64'd0);
    rst_i   = 1'b0;
    flush_i = 1'b0;
    idle_in();
    ready_i = 1'b1;
    tick();
    check("mr_after", 64'(valid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- EX/MEM pipeline register. Captures the EX-stage result bundle: the destination register address from the Rt/Rd select mux, the ALU result, store data and the MEM/WB control bits.
- Presents the bundle to the MEM stage through a valid/ready handshake with a 2-entry skid buffer, so a MEM stall never needs a combinational path back into EX.
- Also drives the EX/MEM forwarding tap used by the forwarding unit.

Parameters:
- XLEN, 32, data path width (ALU result, store data).
- REG_ADDR_W, 6, destination register address width (matches the Rt/Rd mux output).

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- flush_i  input  1  kill all held and incoming entries (branch/exception).
- valid_i  input  1  EX presents a bundle this cycle.
- ready_o  output  1  this block can accept a bundle; registered.
- rd_addr_i  input  REG_ADDR_W  destination register (Rt or Rd after select).
- alu_result_i  input  XLEN  ALU result / memory address.
- store_data_i  input  XLEN  data for stores.
- reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i  input  1 each  control bits.
- valid_o  output  1  head entry valid toward MEM.
- ready_i  input  1  MEM accepts the head entry.
- rd_addr_o  output  REG_ADDR_W; alu_result_o, store_data_o  output  XLEN; reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o  output  1 each; head-entry payload.
- fwd_valid_o  output  1  = valid_o & reg_write_o.
- fwd_addr_o  output  REG_ADDR_W  = rd_addr_o.
- fwd_data_o  output  XLEN  = alu_result_o.

Behaviour:
- Reset: all entries invalid, payload registers 0. valid_o=0, all payload outputs 0, fwd_valid_o=0, ready_o=1.
- Transfer definitions:
  - In-transfer: valid_i & ready_o.
  - Out-transfer: valid_o & ready_i.
- Latency: 1 cycle. An accepted bundle appears on the outputs the next cycle when the block was empty or drained that cycle.
- States, from the occupancy of main and skid:
  - EMPTY: valid_o=0, ready_o=1.
  - ONE: main full; valid_o=1, ready_o=1.
  - FULL: main and skid full; valid_o=1, ready_o=0.
- Transitions (no flush):
  - EMPTY + in -> ONE.
  - ONE + in & out -> ONE; new bundle moves into main.
  - ONE + in & !out -> FULL; new bundle goes to skid.
  - ONE + out & !in -> EMPTY.
  - FULL + out -> ONE; skid moves to main.
  - FULL + !out -> FULL; hold.
  - FULL never receives in-transfers, since ready_o=0.
- ready_o is registered and deasserts only in FULL, so no combinational ready_i->ready_o path exists.
- Flush: flush_i=1 at an edge forces EMPTY next cycle (valid_o=0, ready_o=1).
  - Flush overrides a simultaneous in-transfer: the bundle is dropped.
  - A simultaneous out-transfer still completes on the MEM side.
- $zero write kill: if rd_addr_i==0 at capture, reg_write is stored as 0, so forwarding and WB never target register 0.
- Output payload is held stable while valid_o=1 & ready_i=0.
- Order is strictly FIFO; no entry is duplicated or reordered.
- Payload regs may hold stale data when invalid, except after reset (0). fwd_valid_o gates use.
- Reset asserted mid-operation behaves identically to power-on reset at the next edge; it overrides flush_i and valid_i.

Optional Feature:
- Macro: EX_MEM_PERF_EN.
- Defined: adds output stall_cnt_o [31:0], a saturating counter.
  - Increments each cycle valid_o=1 & ready_i=0.
  - Holds at 32'hFFFF_FFFF.
  - Cleared by rst_i only; flush does not clear it.
- Not defined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Shared package ex_mem_pkg:
  - XLEN and REG_ADDR_W constants.
  - typedef struct ex_mem_payload_t {rd_addr, alu_result, store_data, reg_write, mem_read, mem_write, mem_to_reg}.
  - Occupancy state enum {EMPTY, ONE, FULL}.
- One sub-module: pipe_skid_buf, a generic 2-entry valid/ready skid buffer parameterised on payload width, with a flush input.
- ex_mem_skid_reg packs the struct, applies the $zero kill, and drives the forwarding tap and the optional counter.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles -> valid_o=0, ready_o=1, fwd_valid_o=0, all payload outputs 0.
- Streaming: ready_i=1, bundles rd=5/alu=0x10, rd=6/alu=0x20, rd=7/alu=0x30 on consecutive cycles -> same values on outputs one cycle later each; ready_o stays 1.
- Backpressure: ready_i=0, send rd=8 then rd=9 -> FULL and ready_o=0 on the next cycle; a third bundle is held off by EX. Release ready_i -> outputs rd=8 then rd=9 in order, no loss.
- Flush collision: in state ONE with valid_i=1 (rd=10), flush_i=1 -> next cycle valid_o=0, ready_o=1; rd=10 never appears.
- $zero kill: rd_addr_i=0, reg_write_i=1, alu=0xDEAD -> reg_write_o=0, fwd_valid_o=0, alu_result_o=0xDEAD.
- EX_MEM_PERF_EN: hold valid_o=1, ready_i=0 for 7 cycles -> stall_cnt_o=7; flush leaves it at 7; reset clears it to 0.
